// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// One-entry holding buffer allows back-to-back frames with no idle gap.
module uart_tx (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        send_i,
    input  logic [7:0]  data_i,
    input  logic        parity_bit_i,
    input  logic        parity_even_i,
    input  logic [15:0] clock_divider_i,
    output logic        serial_o,
    output logic        busy_o,
    output logic        full_o,
    output logic        done_o,
    output logic        overflow_o
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  buf_q, buf_d;
    logic        full_q, full_d;
    logic        send_q, send_d;
    logic        par_en_q, par_en_d;
    logic        par_val_q, par_val_d;
    logic        serial_q, serial_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;

    logic        req;
    logic        tick;
    logic        last_stop;
    logic        load_slot;
    logic        frame_go;
    logic [7:0]  src;
    logic [15:0] div_eff;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        buf_d     = buf_q;
        full_d    = full_q;
        par_en_d  = par_en_q;
        par_val_d = par_val_q;
        send_d    = send_i;
        done_d    = 1'b0;
        ovf_d     = 1'b0;
        frame_go  = 1'b0;
        src       = data_i;
        div_eff   = (clock_divider_i == 16'd0) ? 16'd1 : clock_divider_i;

        req       = send_i & ~send_q;
        tick      = (cnt_q == 16'd0);
        last_stop = (state_q == STOP) && tick;
        load_slot = (state_q == IDLE) || last_stop;

        // Bit timing within a running frame; the final stop cycle is handled as a load slot.
        if (state_q != IDLE && !last_stop) begin
            if (!tick) begin
                cnt_d = cnt_q - 16'd1;
            end else begin
                cnt_d = div_q - 16'd1;
                case (state_q)
                    START:  state_d = DATA;
                    DATA: begin
                        shift_d = shift_q >> 1;
                        if (bit_q == 3'd7) begin
                            state_d = par_en_q ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                    PARITY: state_d = STOP;
                    default: state_d = state_q;
                endcase
            end
        end

        if (load_slot) begin
            if (full_q) begin
                // Buffered byte goes first; a same-cycle request refills the freed slot.
                src      = buf_q;
                frame_go = 1'b1;
                if (req) begin
                    buf_d = data_i;
                end else begin
                    full_d = 1'b0;
                end
            end else if (req) begin
                src      = data_i;
                frame_go = 1'b1;
            end
        end else if (req) begin
            if (full_q) begin
                ovf_d = 1'b1;
            end else begin
                buf_d  = data_i;
                full_d = 1'b1;
            end
        end

        if (last_stop) begin
            done_d = 1'b1;
            if (!frame_go) begin
                state_d = IDLE;
            end
        end

        if (frame_go) begin
            state_d   = START;
            shift_d   = src;
            div_d     = div_eff;
            cnt_d     = div_eff - 16'd1;
            bit_d     = 3'd0;
            par_en_d  = parity_bit_i;
            par_val_d = (^src) ^ ~parity_even_i;
        end

        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = par_val_d;
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            div_q     <= 16'd1;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            buf_q     <= 8'd0;
            full_q    <= 1'b0;
            send_q    <= 1'b1;
            par_en_q  <= 1'b0;
            par_val_q <= 1'b0;
            serial_q  <= 1'b1;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            buf_q     <= buf_d;
            full_q    <= full_d;
            send_q    <= send_d;
            par_en_q  <= par_en_d;
            par_val_q <= par_val_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    assign serial_o   = serial_q;
    assign busy_o     = (state_q != IDLE);
    assign full_o     = full_q;
    assign done_o     = done_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: expected line waveform built from frame rules, compared cycle by cycle.
module tb_uart_tx;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        send_i;
    logic [7:0]  data_i;
    logic        parity_bit_i;
    logic        parity_even_i;
    logic [15:0] clock_divider_i;
    logic        serial_o;
    logic        busy_o;
    logic        full_o;
    logic        done_o;
    logic        overflow_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    bit exp_q[$];

    uart_tx dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .send_i          (send_i),
        .data_i          (data_i),
        .parity_bit_i    (parity_bit_i),
        .parity_even_i   (parity_even_i),
        .clock_divider_i (clock_divider_i),
        .serial_o        (serial_o),
        .busy_o          (busy_o),
        .full_o          (full_o),
        .done_o          (done_o),
        .overflow_o      (overflow_o)
    );

    always #5 clock_i = ~clock_i;

    // Reference: a frame is the list of line levels, each held for max(divider,1) cycles.
    function automatic void append_frame(input logic [7:0] d, input int dv, input bit pen, input bit peven);
        int dd;
        bit bits[$];
        dd = (dv == 0) ? 1 : dv;
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(d[k]);
        if (pen) bits.push_back(peven ? (^d) : ~(^d));
        bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int r = 0; r < dd; r++) exp_q.push_back(bits[k]);
        end
    endfunction

    task automatic test_reset();
        reset_i = 1'b0; send_i = 1'b0; data_i = 8'h00;
        parity_bit_i = 1'b0; parity_even_i = 1'b0; clock_divider_i = 16'd2;
        repeat (3) @(negedge clock_i);
        vec_cnt++; if (serial_o !== 1'b1) begin err_cnt++; $display("FAIL reset_serial: got %b want 1", serial_o); end
        vec_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        vec_cnt++; if (full_o !== 1'b0) begin err_cnt++; $display("FAIL reset_full: got %b want 0", full_o); end
        vec_cnt++; if (done_o !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b want 0", done_o); end
        vec_cnt++; if (overflow_o !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
        reset_i = 1'b1;
        repeat (2) @(negedge clock_i);
        vec_cnt++; if (serial_o !== 1'b1 || busy_o !== 1'b0) begin
            err_cnt++; $display("FAIL post_reset_idle: serial %b busy %b want 1 0", serial_o, busy_o);
        end
    endtask

    // Single frame; optionally scramble the config inputs mid-frame to show they were latched.
    task automatic test_frame(input logic [7:0] d, input logic [15:0] dv, input bit pen, input bit peven, input bit scramble);
        int n;
        exp_q.delete();
        append_frame(d, int'(dv), pen, peven);
        n = exp_q.size();
        @(negedge clock_i);
        clock_divider_i = dv; parity_bit_i = pen; parity_even_i = peven;
        send_i = 1'b1; data_i = d;
        @(negedge clock_i);
        send_i = 1'b0;
        if (scramble) begin
            clock_divider_i = 16'($urandom_range(1, 5));
            parity_bit_i = 1'($urandom); parity_even_i = 1'($urandom); data_i = 8'($urandom);
        end
        for (int i = 0; i < n; i++) begin
            vec_cnt++; if (serial_o !== exp_q[i]) begin
                err_cnt++; $display("FAIL frame_%h_serial[%0d]: got %b want %b", d, i, serial_o, exp_q[i]);
            end
            vec_cnt++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin
                err_cnt++; $display("FAIL frame_%h_busy[%0d]: busy %b done %b want 1 0", d, i, busy_o, done_o);
            end
            @(negedge clock_i);
        end
        vec_cnt++; if (done_o !== 1'b1 || busy_o !== 1'b0 || serial_o !== 1'b1) begin
            err_cnt++; $display("FAIL frame_%h_end: done %b busy %b serial %b want 1 0 1", d, done_o, busy_o, serial_o);
        end
        @(negedge clock_i);
        vec_cnt++; if (done_o !== 1'b0) begin
            err_cnt++; $display("FAIL frame_%h_done_pulse: got %b want 0", d, done_o);
        end
    endtask

    task automatic test_oneshot();
        int n;
        exp_q.delete();
        append_frame(8'hCC, 2, 1'b0, 1'b0);
        n = exp_q.size();
        @(negedge clock_i);
        clock_divider_i = 16'd2; parity_bit_i = 1'b0;
        send_i = 1'b1; data_i = 8'hCC;
        @(negedge clock_i);
        for (int i = 0; i < 100; i++) begin
            vec_cnt++;
            if (i < n) begin
                if (serial_o !== exp_q[i] || busy_o !== 1'b1) begin
                    err_cnt++; $display("FAIL oneshot[%0d]: serial %b busy %b want %b 1", i, serial_o, busy_o, exp_q[i]);
                end
            end else if (serial_o !== 1'b1 || busy_o !== 1'b0) begin
                err_cnt++; $display("FAIL oneshot_idle[%0d]: serial %b busy %b want 1 0", i, serial_o, busy_o);
            end
            @(negedge clock_i);
        end
        send_i = 1'b0;
    endtask

    task automatic test_buffering();
        int d, n1, n;
        bit want_full, want_done, want_ovf, want_busy;
        d = $urandom_range(2, 4);
        exp_q.delete();
        append_frame(8'h11, d, 1'b0, 1'b0);
        n1 = exp_q.size();
        append_frame(8'h22, d, 1'b0, 1'b0);
        for (int k = 0; k < 12 * d; k++) exp_q.push_back(1'b1);
        n = exp_q.size();
        @(negedge clock_i);
        clock_divider_i = 16'(d); parity_bit_i = 1'b0;
        send_i = 1'b1; data_i = 8'h11;
        @(negedge clock_i);
        send_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            want_busy = (i < 2 * n1);
            want_done = (i == n1) || (i == 2 * n1);
            want_full = (i >= 4) && (i < n1);
            want_ovf  = (i == 9);
            vec_cnt++; if (serial_o !== exp_q[i] || busy_o !== want_busy) begin
                err_cnt++; $display("FAIL buf_line[%0d]: serial %b busy %b want %b %b", i, serial_o, busy_o, exp_q[i], want_busy);
            end
            vec_cnt++; if (full_o !== want_full || done_o !== want_done || overflow_o !== want_ovf) begin
                err_cnt++; $display("FAIL buf_flags[%0d]: full %b done %b ovf %b want %b %b %b",
                                    i, full_o, done_o, overflow_o, want_full, want_done, want_ovf);
            end
            if (i == 3) begin send_i = 1'b1; data_i = 8'h22; end
            if (i == 4) send_i = 1'b0;
            if (i == 8) begin send_i = 1'b1; data_i = 8'h33; end
            if (i == 9) send_i = 1'b0;
            @(negedge clock_i);
        end
    endtask

    task automatic test_simultaneous();
        int d, n1, n;
        logic [7:0] x;
        d = $urandom_range(1, 3);
        x = 8'($urandom);
        exp_q.delete();
        append_frame(x, d, 1'b0, 1'b0);
        n1 = exp_q.size();
        append_frame(8'h44, d, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) exp_q.push_back(1'b1);
        n = exp_q.size();
        @(negedge clock_i);
        clock_divider_i = 16'(d); parity_bit_i = 1'b0;
        send_i = 1'b1; data_i = x;
        @(negedge clock_i);
        send_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            vec_cnt++; if (serial_o !== exp_q[i] || busy_o !== (i < 2 * n1)) begin
                err_cnt++; $display("FAIL simul_line[%0d]: serial %b busy %b want %b %b", i, serial_o, busy_o, exp_q[i], (i < 2 * n1));
            end
            vec_cnt++; if (done_o !== ((i == n1) || (i == 2 * n1)) || full_o !== 1'b0 || overflow_o !== 1'b0) begin
                err_cnt++; $display("FAIL simul_flags[%0d]: done %b full %b ovf %b", i, done_o, full_o, overflow_o);
            end
            if (i == n1 - 1) begin send_i = 1'b1; data_i = 8'h44; end
            if (i == n1) send_i = 1'b0;
            @(negedge clock_i);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock_i);
        clock_divider_i = 16'd2; parity_bit_i = 1'b0;
        send_i = 1'b1; data_i = 8'h00;
        @(negedge clock_i);
        send_i = 1'b0;
        repeat (6) @(negedge clock_i);
        vec_cnt++; if (serial_o !== 1'b0 || busy_o !== 1'b1) begin
            err_cnt++; $display("FAIL rstmid_pre: serial %b busy %b want 0 1", serial_o, busy_o);
        end
        #2;
        reset_i = 1'b0;
        send_i  = 1'b1;
        #1;
        vec_cnt++; if (serial_o !== 1'b1 || busy_o !== 1'b0 || full_o !== 1'b0) begin
            err_cnt++; $display("FAIL rstmid_async: serial %b busy %b full %b want 1 0 0", serial_o, busy_o, full_o);
        end
        repeat (2) @(negedge clock_i);
        reset_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock_i);
            vec_cnt++; if (serial_o !== 1'b1 || busy_o !== 1'b0) begin
                err_cnt++; $display("FAIL rstmid_hold[%0d]: serial %b busy %b want 1 0", i, serial_o, busy_o);
            end
        end
        send_i = 1'b0;
        @(negedge clock_i);
    endtask

    initial begin
        test_reset();
        test_frame(8'h55, 16'd2, 1'b0, 1'b0, 1'b0);
        test_frame(8'hAA, 16'd2, 1'b1, 1'b1, 1'b0);
        test_frame(8'hAB, 16'd2, 1'b1, 1'b0, 1'b0);
        test_oneshot();
        test_buffering();
        test_simultaneous();
        test_reset_mid();
        test_frame(8'($urandom), 16'd0, 1'b0, 1'b0, 1'b0);
        test_frame(8'($urandom), 16'd1, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            test_frame(8'($urandom), 16'($urandom_range(1, 3)), 1'($urandom), 1'($urandom), 1'b1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: the sending end of the link whose receiving end is `uart_rx`, with the same frame format and the same divider and parity controls. A byte presented on `data_i` is framed as a start bit, 8 data bits LSB first, an optional parity bit and one stop bit, then shifted out on `serial_o`. A one-entry holding buffer allows back-to-back frames. Transmission is triggered by the rising edge of `send_i`, a one-shot handshake that mirrors the receiver's `ack_i`.

## Interface
- No parameters. Data width is fixed at 8, divider width at 16.
- `clock_i`, input, 1: single system clock; all logic is rising-edge.
- `reset_i`, input, 1: asynchronous, active-low reset.
- `send_i`, input, 1: transmit request; only its rising edge acts.
- `data_i`, input, 8: byte to send, sampled on the cycle the `send_i` edge is detected.
- `parity_bit_i`, input, 1: 1 adds a parity bit after the data bits.
- `parity_even_i`, input, 1: 1 selects even parity, 0 selects odd.
- `clock_divider_i`, input, 16: bit period in `clock_i` cycles; a value of 0 is treated as 1.
- `serial_o`, output, 1: line output; idles high.
- `busy_o`, output, 1: a frame is being shifted out.
- `full_o`, output, 1: the holding buffer is occupied.
- `done_o`, output, 1: one-cycle pulse when a frame's stop bit completes.
- `overflow_o`, output, 1: one-cycle pulse when a request is dropped.

## Operation
- Edge detect: `send_q` registers `send_i`; a request is `send_i & ~send_q`. `send_q` resets to 1, so `send_i` held high through reset deassertion does not trigger. Holding `send_i` high sends exactly one frame; it must return low for at least 1 cycle before the next request.
- States are IDLE, START, DATA, PARITY, STOP.
  - IDLE to START on a request, or when the holding buffer is full.
  - START to DATA.
  - DATA to PARITY after bit 7 if the latched `parity_bit_i` is 1, otherwise to STOP.
  - PARITY to STOP.
  - STOP to START if a byte is pending, otherwise to IDLE.
- Each state or bit lasts D = max(`clock_divider_i`, 1) cycles, counted by a 16-bit down-counter.
- `clock_divider_i`, `parity_bit_i` and `parity_even_i` are latched at frame load. Changes mid-frame take effect on the next frame.
- Parity bit: even gives XOR of the 8 data bits; odd gives its inverse.
- `serial_o` is registered and driven per state: START 0, DATA shift[0], PARITY the parity bit, STOP 1, IDLE 1.
- Request handling:
  - IDLE: the byte loads directly into the shift register and the frame starts.
  - Busy with buffer empty: the byte goes to the holding buffer and `full_o` rises.
  - Busy with buffer full: the byte is dropped and `overflow_o` pulses.
- Simultaneous events on the final STOP cycle:
  - Buffer full: the buffered byte moves to the shift register, and a same-cycle request loads the freed buffer with no overflow.
  - Buffer empty: a same-cycle request starts the next frame directly.
- `busy_o` is 1 in every state other than IDLE. `full_o` is 1 while the buffer holds a byte.

## Timing
- Reset values: `serial_o`=1, `busy_o`=0, `full_o`=0, `done_o`=0, `overflow_o`=0, state IDLE, holding buffer empty.
- Reset asserted mid-frame forces `serial_o` high immediately (asynchronously); the frame and the buffered byte are discarded.
- Latency: the clock edge that samples the `send_i` rise also drives `serial_o` low and `busy_o` high, so the start bit begins at that edge.
- Frame length is 10·D cycles without parity and 11·D cycles with parity.
- Back-to-back frames have no idle gap: the next start bit follows the last stop cycle directly.
- `done_o` is high for the first cycle after the stop bit, then low. `busy_o` falls at the same edge when nothing is pending.
- `overflow_o` is high for 1 cycle, the cycle after the dropped request is sampled.

## Test plan
- D=2, no parity, send 8'h55: `serial_o` reads 0,1,0,1,0,1,0,1,0,1, each for 2 cycles. `busy_o` is high for 20 cycles, then `done_o` pulses once. A `uart_rx` instance with the same settings reports 8'h55.
- D=2, even parity, send 8'hAA: parity bit 0. Odd parity, send 8'hAB: parity bit 0. Frames last 22 cycles each.
- One-shot: hold `send_i` high for 100 cycles with 8'hCC: exactly one frame is sent, then `serial_o` stays high.
- Buffering: send 8'h11, then pulse 8'h22 mid-frame: `full_o` goes high and the two frames run back-to-back. A third pulse (8'h33) while `full_o` is high gives one `overflow_o` pulse, and 8'h33 is never sent.
- Simultaneous: the request for 8'h44 lands on the last stop cycle with the buffer empty: the next start bit begins at the following edge with no idle cycle.
- Reset mid-frame: assert `reset_i` low during DATA: `serial_o` goes high immediately. With `send_i` held high through release, no frame starts.
- Divider 0: behaves identically to divider 1, giving a 10-cycle frame.
